// File: rtl/turn_queue.sv
//------------------------------------------------------------------------------
// Module      : turn_queue
// Description : Per-player turn-command buffer between the keyboard decoder and
//               the game core. Rising edges of the left/right key levels become
//               single turn events. Each player has a small FIFO of pending
//               turns. One turn per player is popped on every game tick and
//               held on the output for the whole tick period.
// Revision    : 1.0 - initial release
//
// Ports
//   CLOCK_50   in   1  system clock, all logic on the rising edge
//   reset_n    in   1  synchronous active-low reset
//   key_left   in   3  level, bit p high while player p's left key is down
//   key_right  in   3  level, bit p high while player p's right key is down
//   game_tick  in   1  single-cycle strobe, one per game step
//   flush      in   1  level, clears all queues while high
//   turn       out  6  player p in turn[2p+1:2p]: 01 right, 10 left, 00 straight
//   pending    out  3  bit p high while player p's queue is non-empty
//   dropped    out  3  sticky, bit p set when a player-p event hit a full queue
//
// Parameter
//   DEPTH      queue entries per player, legal range 1..4
//------------------------------------------------------------------------------
`default_nettype none

module turn_queue #(
  parameter int DEPTH = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [2:0] key_left,
  input  logic [2:0] key_right,
  input  logic       game_tick,
  input  logic       flush,
  output logic [5:0] turn,
  output logic [2:0] pending,
  output logic [2:0] dropped
);

  localparam logic [2:0] c_DEPTH = 3'(DEPTH);
  localparam logic [1:0] c_LAST  = 2'(DEPTH - 1);

  // Previous key levels for edge detection. They follow the keys on every
  // edge, including during reset and flush, so a key already held when the
  // game restarts never produces an event.
  logic [2:0] r_prev_l;
  logic [2:0] r_prev_r;

  always_ff @(posedge CLOCK_50) begin
    r_prev_l <= key_left;
    r_prev_r <= key_right;
  end

  logic w_clear;
  assign w_clear = !reset_n || flush;

  for (genvar p = 0; p < 3; p++) begin : g_player
    // Storage is always four slots; only the first DEPTH are used, so the
    // pointers can stay a fixed 2 bits for every legal DEPTH.
    logic [1:0] r_mem [4];
    logic [1:0] r_head;
    logic [2:0] r_count;
    logic [1:0] r_turn;
    logic       r_dropped;

    logic       w_ev_l;
    logic       w_ev_r;
    logic       w_push;
    logic [1:0] w_code;
    logic       w_nonempty;
    logic       w_full;
    logic       w_pop;
    logic       w_accept;
    logic [2:0] w_sum;
    logic [1:0] w_tail;
    logic [1:0] w_head_nxt;

    assign w_ev_l     = key_left[p]  & ~r_prev_l[p];
    assign w_ev_r     = key_right[p] & ~r_prev_r[p];
    // Simultaneous left and right cancel out.
    assign w_push     = w_ev_l ^ w_ev_r;
    assign w_code     = w_ev_l ? 2'b10 : 2'b01;
    assign w_nonempty = (r_count != 3'd0);
    assign w_full     = (r_count == c_DEPTH);
    assign w_pop      = game_tick && w_nonempty;
    // A full queue still accepts a push when a tick frees the head slot in
    // the same cycle; the tail then lands exactly on the slot being popped.
    assign w_accept   = w_push && (!w_full || game_tick);

    assign w_sum      = {1'b0, r_head} + r_count;
    assign w_tail     = (w_sum >= c_DEPTH) ? 2'(w_sum - c_DEPTH) : w_sum[1:0];
    assign w_head_nxt = (r_head == c_LAST) ? 2'd0 : r_head + 2'd1;

    always_ff @(posedge CLOCK_50) begin
      if (w_clear) begin
        r_head    <= 2'd0;
        r_count   <= 3'd0;
        r_turn    <= 2'b00;
        r_dropped <= 1'b0;
      end else begin
        if (game_tick) begin
          r_turn <= w_nonempty ? r_mem[r_head] : 2'b00;
        end
        if (w_pop) begin
          r_head <= w_head_nxt;
        end
        if (w_accept) begin
          r_mem[w_tail] <= w_code;
        end else if (w_push) begin
          r_dropped <= 1'b1;
        end
        if (w_pop && !w_accept) begin
          r_count <= r_count - 3'd1;
        end else if (!w_pop && w_accept) begin
          r_count <= r_count + 3'd1;
        end
      end
    end

    assign turn[2*p+1:2*p] = r_turn;
    assign pending[p]      = w_nonempty;
    assign dropped[p]      = r_dropped;
  end

endmodule

`default_nettype wire

// File: tb/tb_turn_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_turn_queue
// Description : Directed self-checking bench for turn_queue (DEPTH = 2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_turn_queue;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic [2:0] key_left;
  logic [2:0] key_right;
  logic       game_tick;
  logic       flush;
  logic [5:0] turn;
  logic [2:0] pending;
  logic [2:0] dropped;

  int n_checks = 0;
  int n_errors = 0;

  turn_queue #(.DEPTH(2)) u_dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .key_left  (key_left),
    .key_right (key_right),
    .game_tick (game_tick),
    .flush     (flush),
    .turn      (turn),
    .pending   (pending),
    .dropped   (dropped)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic tick();
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
  endtask

  task automatic pulse_l(input int p);
    key_left[p] = 1'b1;
    step();
    key_left[p] = 1'b0;
    step();
  endtask

  task automatic pulse_r(input int p);
    key_right[p] = 1'b1;
    step();
    key_right[p] = 1'b0;
    step();
  endtask

  // Fill every queue, then clear with flush or reset while keys are held.
  task automatic clear_scenario(input bit use_reset);
    pulse_l(0); pulse_l(0); pulse_l(1); pulse_l(1); pulse_l(2); pulse_l(2);
    tick();
    check("clr_pre_turn", {2'b0, turn}, 8'b00101010);
    pulse_l(0); pulse_l(1); pulse_l(2); pulse_l(2);
    check("clr_pre_pend", {5'b0, pending}, 8'b00000111);
    check("clr_pre_drop2", {7'b0, dropped[2]}, 8'd1);
    key_left[1] = 1'b1;        // held key, p1 already full
    step();
    check("clr_pre_drop21", {6'b0, dropped[2:1]}, 8'b00000011);
    key_right[2] = 1'b1;       // rises while the clear is active
    game_tick    = 1'b1;       // must be ignored
    if (use_reset) reset_n = 1'b0;
    else           flush   = 1'b1;
    step();
    reset_n   = 1'b1;
    flush     = 1'b0;
    game_tick = 1'b0;
    check("clr_turn", {2'b0, turn}, 8'd0);
    check("clr_pend", {5'b0, pending}, 8'd0);
    check("clr_drop", {5'b0, dropped}, 8'd0);
    step(); step(); step();
    check("clr_held_pend", {5'b0, pending}, 8'd0);
    key_left[1]  = 1'b0;
    key_right[2] = 1'b0;
    step();
    pulse_l(1);
    check("clr_repress_pend", {5'b0, pending}, 8'b00000010);
    tick();
    check("clr_repress_turn", {2'b0, turn}, 8'b00001000);
    check("clr_repress_empty", {5'b0, pending}, 8'd0);
    tick();
    check("clr_final_turn", {2'b0, turn}, 8'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    key_left  = 3'b000;
    key_right = 3'b000;
    game_tick = 1'b0;
    flush     = 1'b0;
    step(); step();
    reset_n = 1'b1;
    check("rst_turn", {2'b0, turn}, 8'd0);
    check("rst_pend", {5'b0, pending}, 8'd0);
    check("rst_drop", {5'b0, dropped}, 8'd0);

    // Single press held for 10 cycles.
    key_left[0] = 1'b1;
    step();
    check("single_pend", {5'b0, pending}, 8'b00000001);
    for (int i = 0; i < 9; i++) step();
    key_left[0] = 1'b0;
    step();
    check("single_hold_pend", {5'b0, pending}, 8'b00000001);
    tick();
    check("single_turn", {2'b0, turn}, 8'b00000010);
    check("single_pend_after", {5'b0, pending}, 8'd0);
    step();
    check("single_turn_held", {2'b0, turn}, 8'b00000010);
    tick();
    check("single_turn_next", {2'b0, turn}, 8'd0);

    // Double tap on player 1.
    pulse_r(1); pulse_r(1);
    check("dtap_pend", {5'b0, pending}, 8'b00000010);
    tick();
    check("dtap_t1", {2'b0, turn}, 8'b00000100);
    check("dtap_pend1", {5'b0, pending}, 8'b00000010);
    tick();
    check("dtap_t2", {2'b0, turn}, 8'b00000100);
    check("dtap_pend2", {5'b0, pending}, 8'd0);
    tick();
    check("dtap_t3", {2'b0, turn}, 8'd0);

    // Overflow on player 2.
    pulse_l(2); pulse_l(2);
    check("ovf_nodrop", {5'b0, dropped}, 8'd0);
    pulse_l(2);
    check("ovf_drop", {5'b0, dropped}, 8'b00000100);
    tick();
    check("ovf_t1", {6'b0, turn[5:4]}, 8'b00000010);
    tick();
    check("ovf_t2", {6'b0, turn[5:4]}, 8'b00000010);
    tick();
    check("ovf_t3", {6'b0, turn[5:4]}, 8'd0);
    check("ovf_drop_sticky", {5'b0, dropped}, 8'b00000100);

    // Left and right rising together on player 0.
    key_left[0]  = 1'b1;
    key_right[0] = 1'b1;
    step();
    check("conf_pend", {5'b0, pending}, 8'd0);
    key_left[0]  = 1'b0;
    key_right[0] = 1'b0;
    step();
    tick();
    check("conf_turn", {2'b0, turn}, 8'd0);
    check("conf_drop0", {7'b0, dropped[0]}, 8'd0);

    // Push on pop with an empty queue.
    key_right[0] = 1'b1;
    game_tick    = 1'b1;
    step();
    game_tick    = 1'b0;
    key_right[0] = 1'b0;
    check("pop_empty_turn", {6'b0, turn[1:0]}, 8'd0);
    check("pop_empty_pend", {7'b0, pending[0]}, 8'd1);
    step();
    tick();
    check("pop_empty_next", {6'b0, turn[1:0]}, 8'b00000001);
    check("pop_empty_pend2", {7'b0, pending[0]}, 8'd0);

    // Push on pop with a full queue: left, left, then right during a tick.
    pulse_l(0); pulse_l(0);
    key_right[0] = 1'b1;
    game_tick    = 1'b1;
    step();
    game_tick    = 1'b0;
    key_right[0] = 1'b0;
    check("pop_full_turn", {6'b0, turn[1:0]}, 8'b00000010);
    check("pop_full_drop0", {7'b0, dropped[0]}, 8'd0);
    step();
    tick();
    check("pop_full_t2", {6'b0, turn[1:0]}, 8'b00000010);
    check("pop_full_pend", {7'b0, pending[0]}, 8'd1);
    tick();
    check("pop_full_t3", {6'b0, turn[1:0]}, 8'b00000001);
    tick();
    check("pop_full_t4", {6'b0, turn[1:0]}, 8'd0);
    check("pop_full_drop0_end", {7'b0, dropped[0]}, 8'd0);

    clear_scenario(1'b0);
    clear_scenario(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/turn_queue.md
# turn_queue

Per-player turn-command buffer between the PS/2 keyboard controller and game_data. It converts level key-make bits into single turn events and holds up to DEPTH pending turns per player. On each game tick it pops one turn per player and presents it on `turn` for the whole tick period. A quick double-tap between two 20 Hz ticks therefore produces two consecutive turns instead of being lost.

## Interface
- DEPTH, 2: queue entries per player; legal range 1..4.
- CLOCK_50  in  1  system clock, 50 MHz; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- key_left  in  3  level, bit p high while player p's left key is down (make_lut bit).
- key_right  in  3  level, bit p high while player p's right key is down.
- game_tick  in  1  single-cycle pulse, one per game step (the counter==0 strobe).
- flush  in  1  level; high while game_ctrl is in G_IDLE (reset_game); clears everything.
- turn  out  6  player p occupies turn[2p+1:2p]; 01 = right (dir+1), 10 = left (dir−1), 00 = straight.
- pending  out  3  bit p high when player p's queue is non-empty.
- dropped  out  3  sticky; bit p is set when a player-p event is discarded because the queue was full.

## Operation
- Edge detect:
  - Registers prevL[2:0] and prevR[2:0] track the key inputs.
  - evL[p] = key_left[p] & ~prevL[p]; evR likewise.
  - During reset and during flush, prev registers load the current key values, so a key already held never generates an event.
- Event resolution per player per cycle:
  - evL only: push 10.
  - evR only: push 01.
  - Both, or neither: no push.
- Queue per player:
  - 2-bit entries, circular buffer with head pointer and count (0..DEPTH).
  - Pointers wrap modulo DEPTH.
- Pop: on game_tick, every player pops simultaneously.
  - turn field ← head entry, count decrements.
  - An empty queue loads 00.
- Same-cycle push and pop:
  - Pop acts first on the pre-cycle contents.
  - Queue empty: turn ← 00, pushed entry is stored, count becomes 1.
  - Queue full: head is popped and the push is accepted, count stays DEPTH, dropped unchanged.
- Full without pop: the push is discarded and dropped[p] is set to 1.
- Flush:
  - Takes priority over game_tick and over pushes.
  - Counts ← 0, turn ← 00, dropped ← 000, prev ← keys.
- Players are fully independent; one player's queue state never affects another's.

## Timing
- Reset values: turn = 6'b000000, pending = 3'b000, dropped = 3'b000, all counts 0, pointers 0.
- Key-to-queue latency: key_left rises at cycle t → evL at t → entry stored, pending high at t+1.
- Tick latency: game_tick high at cycle t → turn valid at t+1 and held until the cycle after the next game_tick.
  - game_data samples turn on its next game_clk edge.
- turn, pending and dropped are all registered; no combinational path from inputs to outputs.
- Reset asserted mid-operation clears queued entries at the next edge; no partial state survives.
- game_tick asserted during flush is ignored; turn stays 00.

## Test plan
- Single press:
  - Press key_left[0] for 10 cycles before a tick.
  - Required: pending = 001 one cycle after the rising edge.
  - After the tick: turn = 6'b000010, pending = 000.
  - On the next tick: turn = 000000.
- Double tap, DEPTH=2:
  - Two key_right[1] pulses between ticks.
  - Required: tick1 → turn = 6'b000100; tick2 → turn = 6'b000100; tick3 → turn = 0.
- Overflow:
  - Three key_left[2] pulses between ticks.
  - Required: dropped = 100 after the third pulse.
  - Consecutive ticks give turn[5:4] = 10, 10, then 00.
  - dropped stays 100 until flush.
- Conflict:
  - key_left[0] and key_right[0] rise in the same cycle.
  - Required: no push, pending = 000, turn stays 00 after the next tick.
- Push on pop:
  - Empty queue; key_right[0] rises in the same cycle as game_tick.
  - Required: turn[1:0] = 00 after that tick, pending[0] = 1.
  - After the following tick: turn[1:0] = 01.
  - Repeat with a full queue: count stays 2 and dropped[0] = 0.
- Flush and reset:
  - Fill all queues, then assert flush for one cycle while a key is held.
  - Required: turn = 0, pending = 0, dropped = 0.
  - Releasing and re-pressing the held key produces exactly one event.
  - Repeat using reset_n = 0 in place of flush; same outcome.
